// File: rtl/svk_apb_mst_bridge_if.sv
// APB4 bus bundle between the requester bridge (master modport) and an APB
// completer (slave modport).
interface svk_apb_mst_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [2:0]            pprot;
  logic [USER_WIDTH-1:0] puser;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot, puser,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot, puser,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/svk_apb_mst_bridge.sv
// APB4 requester: one valid/ready request becomes a SETUP/ACCESS transfer and a
// valid/ready response. Define SVK_APB_MST_TIMEOUT_EN to add the ACCESS watchdog.
module svk_apb_mst_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int USER_WIDTH     = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_strb,
  input  logic [2:0]            req_prot,
  input  logic [USER_WIDTH-1:0] req_user,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  svk_apb_mst_bridge_if.master  apb
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("svk_apb_mst_bridge: TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [2:0]            pprot_q, pprot_d;
  logic [USER_WIDTH-1:0] puser_q, puser_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  req_accept;
  logic                  timeout_hit;

  // Held low during reset so every output reads 0 while preset is asserted.
  assign req_ready  = ~preset & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));
  assign req_accept = req_valid & req_ready;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (apb.pready || timeout_hit) state_d = RESP;
      RESP: begin
        if (req_accept)     state_d = SETUP;
        else if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    pprot_d      = pprot_q;
    puser_d      = puser_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
    if (req_accept) begin
      paddr_d   = req_addr;
      pwrite_d  = req_write;
      pwdata_d  = req_write ? req_wdata : '0;
      pstrb_d   = req_write ? req_strb : '0;
      pprot_d   = req_prot;
      puser_d   = req_user;
      psel_d    = 1'b1;
      penable_d = 1'b0;
    end
    case (state_q)
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        // A watchdog abort completes like an errored transfer with no data.
        if (apb.pready || timeout_hit) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = (apb.pready && !pwrite_q) ? apb.prdata : '0;
          rsp_slverr_d = apb.pready ? apb.pslverr : 1'b1;
        end
      end
      RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      pprot_q      <= '0;
      puser_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      pprot_q      <= pprot_d;
      puser_q      <= puser_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
    end
  end

`ifdef SVK_APB_MST_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        rsp_timeout_q, rsp_timeout_d;

  // The limit is compared against the registered count, so pready in the
  // limit cycle still wins and completes normally.
  assign timeout_hit = (state_q == ACCESS) && (wait_cnt_q == TIMEOUT_LIMIT);

  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    rsp_timeout_d = rsp_timeout_q;
    if (state_q == SETUP) begin
      wait_cnt_d = '0;
    end else if (state_q == ACCESS) begin
      if (apb.pready)       rsp_timeout_d = 1'b0;
      else if (timeout_hit) rsp_timeout_d = 1'b1;
      else                  wait_cnt_d    = wait_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wait_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign apb.paddr   = paddr_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;
  assign apb.pprot   = pprot_q;
  assign apb.puser   = puser_q;

endmodule
